// File: rtl/maxpool_stage.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_stage
//  Purpose  : 2x2 stride-2 max pooling over a raster pixel stream, half-row buffer
//  Revision : 1.0 - initial release
// ============================================================================
module maxpool_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_DIM     = 26
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            frame_clear_i,
  input  logic [DATA_WIDTH-1:0]                           pixel_i,
  input  logic                                            pixel_valid_i,
  output logic [DATA_WIDTH-1:0]                           pixel_o,
  output logic                                            pixel_valid_o,
  output logic                                            pool_done_o,
  output logic [$clog2((IN_DIM/2)*(IN_DIM/2)+1)-1:0]      out_count_o
);

  localparam int OUT_DIM   = IN_DIM / 2;
  localparam int OUT_TOTAL = OUT_DIM * OUT_DIM;
  localparam int CNT_W     = $clog2(OUT_TOTAL + 1);
  localparam int COL_W     = ($clog2(IN_DIM) < 2) ? 2 : $clog2(IN_DIM);
  localparam int IDX_W     = COL_W - 1;
  localparam int BUF_DEPTH = 1 << IDX_W;

  localparam logic [COL_W-1:0] c_col_last     = COL_W'(IN_DIM - 1);
  localparam logic [COL_W-1:0] c_row_last     = COL_W'(IN_DIM - 1);
  localparam logic [COL_W-1:0] c_row_pre_last = COL_W'(IN_DIM - 2);
  localparam logic [CNT_W-1:0] c_last_cnt     = CNT_W'(OUT_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam bit               c_odd_dim      = (IN_DIM % 2) == 1;

  typedef enum logic [1:0] {
    EVEN_ROW    = 2'd0,
    ODD_ROW     = 2'd1,
    DISCARD_ROW = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [COL_W-1:0]        r_col;
  logic [COL_W-1:0]        r_row;
  logic [DATA_WIDTH-1:0]   r_pair;
  logic [DATA_WIDTH-1:0]   r_pixel;
  logic                    r_valid;
  logic                    r_done;
  logic [CNT_W-1:0]        r_out_count;
  logic [DATA_WIDTH-1:0]   r_row_buf [BUF_DEPTH];

  logic                    w_accept;
  logic                    w_odd_col;
  logic                    w_col_wrap;
  logic                    w_row_wrap;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_hmax;
  logic [DATA_WIDTH-1:0]   w_buf_rd;
  logic [DATA_WIDTH-1:0]   w_vmax;
  logic                    w_buf_we;
  logic                    w_emit;
  logic                    w_last_out;

  assign w_accept   = pixel_valid_i & ~frame_clear_i;
  assign w_odd_col  = r_col[0];
  assign w_col_wrap = (r_col == c_col_last);
  assign w_row_wrap = (r_row == c_row_last);
  assign w_idx      = r_col[COL_W-1:1];
  assign w_hmax     = (pixel_i > r_pair) ? pixel_i : r_pair;
  assign w_buf_rd   = r_row_buf[w_idx];
  assign w_vmax     = (w_hmax > w_buf_rd) ? w_hmax : w_buf_rd;
  assign w_buf_we   = w_accept & w_odd_col & (r_state == EVEN_ROW);
  assign w_emit     = w_accept & w_odd_col & (r_state == ODD_ROW);
  assign w_last_out = (r_out_count == c_last_cnt);

  always_comb begin
    w_state_next = r_state;
    if (w_accept && w_col_wrap) begin
      case (r_state)
        EVEN_ROW:    w_state_next = ODD_ROW;
        // With an odd side length the final row has no partner and is dropped
        ODD_ROW:     w_state_next = (c_odd_dim && (r_row == c_row_pre_last)) ? DISCARD_ROW : EVEN_ROW;
        DISCARD_ROW: w_state_next = EVEN_ROW;
        default:     w_state_next = EVEN_ROW;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EVEN_ROW;
    end else if (frame_clear_i) begin
      r_state <= EVEN_ROW;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pair      <= '0;
      r_pixel     <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_out_count <= '0;
    end else if (frame_clear_i) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pair      <= '0;
      r_pixel     <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_valid <= w_emit;
      r_done  <= w_emit & w_last_out;
      if (w_emit) begin
        r_pixel <= w_vmax;
      end
      // The count holds the frame total for exactly the done cycle
      if (r_done) begin
        r_out_count <= w_emit ? c_cnt_one : '0;
      end else if (w_emit) begin
        r_out_count <= r_out_count + c_cnt_one;
      end
      if (w_accept) begin
        if (!w_odd_col) begin
          r_pair <= pixel_i;
        end
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_wrap ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_buf_we) begin
      r_row_buf[w_idx] <= w_hmax;
    end
  end

  assign pixel_o       = r_pixel;
  assign pixel_valid_o = r_valid;
  assign pool_done_o   = r_done;
  assign out_count_o   = r_out_count;

endmodule
`default_nettype wire
